// File: rtl/gf2_matvec_ctrl.sv
// Sequencing controller for an N x N GF(2) matrix-vector multiply: latches one job,
// feeds one row per cycle to an external dot-product unit and returns the result vector.
// Optional GF2_MATVEC_B2B_EN: accept the next job on the same edge that retires a result.
module gf2_matvec_ctrl #(
  parameter int unsigned N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N-1:0]   in_mat,
  input  logic [N-1:0]     in_vec,
  output logic [N-1:0]     dp_a,
  output logic [N-1:0]     dp_b,
  input  logic             dp_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_vec,
  output logic             busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [N*N-1:0]    mat_q, mat_d;
  logic [N-1:0]      vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      res_q, res_d;
  logic              accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mat_d     = mat_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_vec   = '0;
    dp_a      = '0;
    dp_b      = '0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        in_ready = ~rst;
      end
      RUN: begin
        dp_a         = mat_q[cnt_q*N +: N];
        dp_b         = vec_q;
        res_d[cnt_q] = dp_d;
        if (cnt_q == CW'(N-1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_vec   = res_q;
`ifdef GF2_MATVEC_B2B_EN
        in_ready  = out_ready & ~rst;
`endif
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A load overrides whatever the state decode chose, so DONE can hand off straight to RUN.
    accept = in_valid & in_ready;
    if (accept) begin
      state_d = RUN;
      mat_d   = in_mat;
      vec_d   = in_vec;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

endmodule

// File: tb/tb_gf2_matvec_ctrl.sv
// Directed bench for gf2_matvec_ctrl: N=3 table of jobs plus corner sequences, and an N=4 job.
module tb_gf2_matvec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, dp_d, out_valid, out_ready, busy;
  logic [8:0] in_mat;
  logic [2:0] in_vec, dp_a, dp_b, out_vec;

  logic        in_valid4, in_ready4, dp_d4, out_valid4, out_ready4, busy4;
  logic [15:0] in_mat4;
  logic [3:0]  in_vec4, dp_a4, dp_b4, out_vec4;

  int unsigned errors = 0;
  int unsigned checks = 0;

`ifdef GF2_MATVEC_B2B_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 5;
`endif

  always #5 clk = ~clk;

  assign dp_d  = ^(dp_a & dp_b);
  assign dp_d4 = ^(dp_a4 & dp_b4);

  gf2_matvec_ctrl #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mat(in_mat), .in_vec(in_vec), .dp_a(dp_a), .dp_b(dp_b), .dp_d(dp_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .busy(busy)
  );

  gf2_matvec_ctrl #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_mat(in_mat4), .in_vec(in_vec4), .dp_a(dp_a4), .dp_b(dp_b4), .dp_d(dp_d4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_vec(out_vec4), .busy(busy4)
  );

  typedef struct {
    string      nm;
    logic [8:0] mat;
    logic [2:0] vec;
    logic [2:0] exp;
  } job_t;

  job_t tbl[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_job3(input string nm, input logic [8:0] mat, input logic [2:0] vec,
                         input logic [2:0] exp);
    chk({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_mat    = mat;
    in_vec    = vec;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_mat   = ~mat;
    in_vec   = ~vec;
    for (int r = 0; r < 3; r++) begin
      chk({nm, " busy run"}, 32'(busy), 32'd1);
      chk({nm, " dp_a"}, 32'(dp_a), 32'(mat[r*3 +: 3]));
      chk({nm, " dp_b"}, 32'(dp_b), 32'(vec));
      chk({nm, " out_valid early"}, 32'(out_valid), 32'd0);
      step();
    end
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " out_vec"}, 32'(out_vec), 32'(exp));
    step();
    chk({nm, " out_valid pulse"}, 32'(out_valid), 32'd0);
    chk({nm, " out_vec zero"}, 32'(out_vec), 32'd0);
    chk({nm, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acc, npulse, p0, p1;
    logic [2:0] v0, v1;

    tbl[0] = '{"tp_a",    9'b111_110_011, 3'b001, 3'b101};
    tbl[1] = '{"tp_b",    9'b111_110_011, 3'b111, 3'b100};
    tbl[2] = '{"zero",    9'b000_000_000, 3'b111, 3'b000};
    tbl[3] = '{"mixed",   9'b100_010_101, 3'b110, 3'b111};

    rst = 1'b1;
    in_valid = 1'b0; in_mat = '0; in_vec = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_mat4 = '0; in_vec4 = '0; out_ready4 = 1'b1;
    #3;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_vec", 32'(out_vec), 32'd0);
    chk("rst dp_a", 32'(dp_a), 32'd0);
    chk("rst dp_b", 32'(dp_b), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      do_job3(tbl[i].nm, tbl[i].mat, tbl[i].vec, tbl[i].exp);
    end

    // Backpressure: result held for 5 cycles
    in_valid = 1'b1; in_mat = 9'b111_110_011; in_vec = 3'b001; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    for (int k = 0; k < 5; k++) begin
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp out_vec", 32'(out_vec), 32'h5);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp busy", 32'(busy), 32'd1);
      step();
    end
    chk("bp still valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp release busy", 32'(busy), 32'd0);
    chk("bp release out_valid", 32'(out_valid), 32'd0);

    // Two jobs with in_valid held high
    in_valid = 1'b1; in_mat = 9'b111_110_011; in_vec = 3'b001; out_ready = 1'b1;
    acc = 0; npulse = 0; p0 = -1; p1 = -1; v0 = '0; v1 = '0;
    for (int c = 0; c < 30; c++) begin
      if (in_valid && in_ready) acc++;
      step();
      if (acc == 1) in_vec = 3'b111;
      if (acc == 2) in_valid = 1'b0;
      if (out_valid) begin
        if (npulse == 0) begin p0 = c; v0 = out_vec; end
        else if (npulse == 1) begin p1 = c; v1 = out_vec; end
        npulse++;
      end
    end
    chk("b2b accepts", 32'(acc), 32'd2);
    chk("b2b pulses", 32'(npulse), 32'd2);
    chk("b2b gap", 32'(p1 - p0), 32'(GAP));
    chk("b2b vec0", 32'(v0), 32'h5);
    chk("b2b vec1", 32'(v1), 32'h4);

    // Reset in RUN cycle 2
    in_valid = 1'b1; in_mat = 9'b111_110_011; in_vec = 3'b001;
    step();
    in_valid = 1'b0;
    step();
    chk("abort in run", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort dp_a", 32'(dp_a), 32'd0);
    chk("abort dp_b", 32'(dp_b), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort out_vec", 32'(out_vec), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post rst in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("post rst no out_valid", 32'(out_valid), 32'd0);
      step();
    end
    do_job3("after abort", 9'b000_000_000, 3'b111, 3'b000);

    // N=4 identity
    in_valid4 = 1'b1; in_mat4 = 16'b1000_0100_0010_0001; in_vec4 = 4'b1010;
    step();
    in_valid4 = 1'b0; in_mat4 = '0; in_vec4 = '0;
    for (int r = 0; r < 4; r++) begin
      chk("n4 dp_a", 32'(dp_a4), 32'(4'b0001 << r));
      chk("n4 out_valid early", 32'(out_valid4), 32'd0);
      step();
    end
    chk("n4 out_valid", 32'(out_valid4), 32'd1);
    chk("n4 out_vec", 32'(out_vec4), 32'hA);
    step();
    chk("n4 busy after", 32'(busy4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
